// File: rtl/ama_riscv_bp_spec.sv
// ama_riscv_bp_spec: conditional branch predictor for the ama-riscv pipeline.
//
// The table holds N-bit saturating counters. It is indexed by PC bits, by global
// history, or by a mix of the two, depending on BP_TYPE_SEL. A speculative GHR
// advances on every accepted prediction. A committed GHR advances on every
// resolve. Predictions that are still waiting for execute sit in a DEPTH-entry
// FIFO. A mispredict or a flush empties the FIFO and rebuilds the speculative
// history from the committed one.
//
// Ports:
//   clk, rst    clock; synchronous active-high reset
//   req_valid   decode presents a conditional branch at req_pc
//   req_pc      PC of the decode branch
//   req_ready   a request can be accepted this cycle
//   pred_taken  combinational prediction for req_pc
//   res_valid   execute resolves the oldest in-flight branch
//   res_taken   actual outcome of that branch
//   mispred     combinational: the head prediction disagrees with res_taken
//   flush       drop all in-flight entries and restore history
//   occupancy   number of in-flight entries
//   res_err     sticky: a resolve arrived while nothing was in flight
//   stat_res    saturating count of resolved branches
//   stat_mis    saturating count of mispredicts

package ama_riscv_bp_pkg;
    localparam int BP_BIMODAL = 0;
    localparam int BP_GLOBAL  = 1;
    localparam int BP_GSELECT = 2;
    localparam int BP_GSHARE  = 3;
endpackage

module ama_riscv_bp_spec #(
    parameter int PC_BITS     = 5,
    parameter int CNT_BITS    = 2,
    parameter int GR_BITS     = 5,
    parameter int DEPTH       = 4,
    parameter int BP_TYPE_SEL = ama_riscv_bp_pkg::BP_GSHARE,
    parameter int STAT_BITS   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    input  logic [31:0]                req_pc,
    output logic                       req_ready,
    output logic                       pred_taken,
    input  logic                       res_valid,
    input  logic                       res_taken,
    output logic                       mispred,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       res_err,
    output logic [STAT_BITS-1:0]       stat_res,
    output logic [STAT_BITS-1:0]       stat_mis
);
    import ama_riscv_bp_pkg::*;

    localparam int MAX_PG = (PC_BITS > GR_BITS) ? PC_BITS : GR_BITS;
    localparam int SHAMT  = (PC_BITS > GR_BITS) ? (PC_BITS - GR_BITS) : 0;
    localparam int IDX_W  = (BP_TYPE_SEL == BP_BIMODAL) ? PC_BITS :
                            (BP_TYPE_SEL == BP_GLOBAL)  ? GR_BITS :
                            (BP_TYPE_SEL == BP_GSELECT) ? (PC_BITS + GR_BITS) : MAX_PG;
    localparam int TBL    = 2 ** IDX_W;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int OCC_W  = PTR_W + 1;
    localparam logic [CNT_BITS-1:0] THR  = CNT_BITS'(1 << (CNT_BITS - 1));
    localparam logic [CNT_BITS-1:0] CMAX = '1;

    logic [CNT_BITS-1:0] cnt [TBL];
    logic [IDX_W-1:0]    q_idx [DEPTH];
    logic                q_pred [DEPTH];
    logic [PTR_W-1:0]    head, tail;
    logic [OCC_W-1:0]    occ;
    logic [GR_BITS-1:0]  spec_ghr, commit_ghr, commit_next;
    logic [IDX_W-1:0]    req_idx, head_idx;
    logic                head_pred, empty, full, res_fire, accept, push;
    logic                unused_pc_bits;

    assign unused_pc_bits = ^{req_pc[31:PC_BITS+2], req_pc[1:0]};

    // Index selection. The gshare history is left-aligned under the PC bits
    // when the PC field is wider than the history.
    generate
        if (BP_TYPE_SEL == BP_BIMODAL) begin : g_bimodal
            assign req_idx = req_pc[PC_BITS+1:2];
        end else if (BP_TYPE_SEL == BP_GLOBAL) begin : g_global
            assign req_idx = spec_ghr;
        end else if (BP_TYPE_SEL == BP_GSELECT) begin : g_gselect
            assign req_idx = {req_pc[PC_BITS+1:2], spec_ghr};
        end else begin : g_gshare
            assign req_idx = IDX_W'(req_pc[PC_BITS+1:2]) ^ (IDX_W'(spec_ghr) << SHAMT);
        end
    endgenerate

    assign head_idx   = q_idx[head];
    assign head_pred  = q_pred[head];
    assign empty      = (occ == '0);
    assign full       = (occ == OCC_W'(DEPTH));
    assign pred_taken = (cnt[req_idx] >= THR);
    assign res_fire   = res_valid && !empty;
    assign mispred    = res_fire && (head_pred != res_taken);

    // Request handshake: a request transfers when req_valid && req_ready.
    // req_ready depends combinationally on res_valid, because a same-cycle pop
    // frees the slot that the push then fills. A transferred request is still
    // dropped when the same cycle mispredicts or flushes.
    assign req_ready  = !full || res_valid;
    assign accept     = req_valid && req_ready;
    assign push       = accept && !mispred && !flush;

    assign commit_next = res_fire ? {commit_ghr[GR_BITS-2:0], res_taken} : commit_ghr;
    assign occupancy   = occ;

    // Counter table. A pop updates the entry that was recorded at predict time.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TBL; i++) cnt[i] <= THR;
        end else if (res_fire) begin
            if (res_taken) begin
                if (cnt[head_idx] != CMAX) cnt[head_idx] <= cnt[head_idx] + 1'b1;
            end else begin
                if (cnt[head_idx] != '0) cnt[head_idx] <= cnt[head_idx] - 1'b1;
            end
        end
    end

    // FIFO payload. When the FIFO is full and a pop happens in the same cycle,
    // tail equals head. The head payload was read combinationally before the
    // edge, so the write can reuse the slot.
    always_ff @(posedge clk) begin
        if (push) begin
            q_idx[tail]  <= req_idx;
            q_pred[tail] <= pred_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            occ        <= '0;
            spec_ghr   <= '0;
            commit_ghr <= '0;
            res_err    <= 1'b0;
            stat_res   <= '0;
            stat_mis   <= '0;
        end else begin
            commit_ghr <= commit_next;
            if (res_valid && empty) res_err <= 1'b1;
            if (res_fire && (stat_res != '1)) stat_res <= stat_res + 1'b1;
            if (mispred && (stat_mis != '1)) stat_mis <= stat_mis + 1'b1;

            if (flush || mispred) begin
                // Speculative history restarts from the post-resolve commit point.
                head     <= '0;
                tail     <= '0;
                occ      <= '0;
                spec_ghr <= commit_next;
            end else begin
                if (res_fire) head <= head + 1'b1;
                if (push) begin
                    tail     <= tail + 1'b1;
                    spec_ghr <= {spec_ghr[GR_BITS-2:0], pred_taken};
                end
                occ <= occ + OCC_W'(push) - OCC_W'(res_fire);
            end
        end
    end
endmodule

// File: tb/tb_ama_riscv_bp_spec.sv
// Directed testbench for ama_riscv_bp_spec. Two instances share the same
// inputs: a bimodal one and the default gshare one. Each phase checks the
// instance that the phase targets.

module tb_ama_riscv_bp_spec;
    import ama_riscv_bp_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_pc;
    logic        res_valid;
    logic        res_taken;
    logic        flush;

    logic        bi_req_ready, bi_pred, bi_mispred, bi_res_err;
    logic [2:0]  bi_occ;
    logic [15:0] bi_stat_res, bi_stat_mis;
    logic        gs_req_ready, gs_pred, gs_mispred, gs_res_err;
    logic [2:0]  gs_occ;
    logic [15:0] gs_stat_res, gs_stat_mis;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ama_riscv_bp_spec #(.BP_TYPE_SEL(BP_BIMODAL)) dut_bi (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_pc(req_pc),
        .req_ready(bi_req_ready), .pred_taken(bi_pred), .res_valid(res_valid),
        .res_taken(res_taken), .mispred(bi_mispred), .flush(flush),
        .occupancy(bi_occ), .res_err(bi_res_err), .stat_res(bi_stat_res),
        .stat_mis(bi_stat_mis)
    );

    ama_riscv_bp_spec #(.BP_TYPE_SEL(BP_GSHARE)) dut_gs (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_pc(req_pc),
        .req_ready(gs_req_ready), .pred_taken(gs_pred), .res_valid(res_valid),
        .res_taken(res_taken), .mispred(gs_mispred), .flush(flush),
        .occupancy(gs_occ), .res_err(gs_res_err), .stat_res(gs_stat_res),
        .stat_mis(gs_stat_mis)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and return all inputs to idle 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        res_valid = 1'b0;
        res_taken = 1'b0;
        flush     = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_pc = '0;
        res_valid = 1'b0; res_taken = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        step();

        // Reset state
        chk("rst_occ", 32'(bi_occ), 0);
        chk("rst_ready", 32'(bi_req_ready), 1);
        chk("rst_res_err", 32'(bi_res_err), 0);
        chk("rst_stat_res", 32'(bi_stat_res), 0);
        chk("rst_stat_mis", 32'(bi_stat_mis), 0);
        chk("rst_spec_ghr", 32'(dut_gs.spec_ghr), 0);

        // Bimodal: pc 0x40 maps to index 0x10, and the counter starts at 2
        req_valid = 1'b1; req_pc = 32'h40; #1;
        chk("bi_pred_init", 32'(bi_pred), 1);
        step();
        chk("bi_occ_1", 32'(bi_occ), 1);
        res_valid = 1'b1; res_taken = 1'b0; #1;
        chk("bi_mis_1", 32'(bi_mispred), 1);
        step();
        req_valid = 1'b1; req_pc = 32'h40; #1;
        chk("bi_pred_after_nt", 32'(bi_pred), 0);
        step();
        res_valid = 1'b1; res_taken = 1'b0; #1;
        chk("bi_mis_2", 32'(bi_mispred), 0);
        step();
        chk("bi_cnt10", 32'(dut_bi.cnt[16]), 0);
        chk("bi_stat_res_2", 32'(bi_stat_res), 2);
        chk("bi_stat_mis_1", 32'(bi_stat_mis), 1);
        req_pc = 32'h40; #1;
        chk("bi_pred_zero", 32'(bi_pred), 0);

        // Bimodal saturation at index 0x11 (pc 0x44)
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_pc = 32'h44; #1;
            chk("sat_pred", 32'(bi_pred), 1);
            step();
            res_valid = 1'b1; res_taken = 1'b1; #1;
            chk("sat_mis", 32'(bi_mispred), 0);
            step();
        end
        chk("sat_cnt3", 32'(dut_bi.cnt[17]), 3);
        req_valid = 1'b1; req_pc = 32'h44; #1;
        step();
        res_valid = 1'b1; res_taken = 1'b0; #1;
        chk("sat_mis_nt", 32'(bi_mispred), 1);
        step();
        chk("sat_cnt2", 32'(dut_bi.cnt[17]), 2);
        chk("sat_stat_res", 32'(bi_stat_res), 8);
        chk("sat_stat_mis", 32'(bi_stat_mis), 2);

        // Gshare: fill the FIFO with four taken predictions
        rst = 1'b1; step();
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_pc = 32'(i * 4); #1;
            chk("gs_fill_pred", 32'(gs_pred), 1);
            step();
        end
        chk("gs_full_occ", 32'(gs_occ), 4);
        chk("gs_full_ready", 32'(gs_req_ready), 0);
        chk("gs_full_ghr", 32'(dut_gs.spec_ghr), 32'b01111);
        req_valid = 1'b1; req_pc = 32'h20; #1;
        chk("gs_fifth_ready", 32'(gs_req_ready), 0);
        step();
        chk("gs_fifth_occ", 32'(gs_occ), 4);
        chk("gs_fifth_ghr", 32'(dut_gs.spec_ghr), 32'b01111);
        req_valid = 1'b1; req_pc = 32'h20; res_valid = 1'b1; res_taken = 1'b1; #1;
        chk("gs_swap_ready", 32'(gs_req_ready), 1);
        chk("gs_swap_mis", 32'(gs_mispred), 0);
        step();
        chk("gs_swap_occ", 32'(gs_occ), 4);
        chk("gs_swap_ghr", 32'(dut_gs.spec_ghr), 32'b11111);
        chk("gs_swap_cghr", 32'(dut_gs.commit_ghr), 32'b00001);

        // Mispredict recovery with three entries in flight
        rst = 1'b1; step();
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_pc = 32'(32'h10 + i * 4); #1;
            chk("mr_pred", 32'(gs_pred), 1);
            step();
        end
        chk("mr_occ3", 32'(gs_occ), 3);
        res_valid = 1'b1; res_taken = 1'b0; req_valid = 1'b1; req_pc = 32'h30; #1;
        chk("mr_mis", 32'(gs_mispred), 1);
        step();
        chk("mr_occ0", 32'(gs_occ), 0);
        chk("mr_spec", 32'(dut_gs.spec_ghr), 0);
        chk("mr_commit", 32'(dut_gs.commit_ghr), 0);
        chk("mr_stat_mis", 32'(gs_stat_mis), 1);
        chk("mr_stat_res", 32'(gs_stat_res), 1);

        // Flush: first build commit_ghr = 00101 from the resolve sequence T, N, T
        rst = 1'b1; step();
        req_valid = 1'b1; req_pc = 32'h40; step();
        res_valid = 1'b1; res_taken = 1'b1; #1;
        chk("fl_mis_a", 32'(gs_mispred), 0);
        step();
        req_valid = 1'b1; req_pc = 32'h40; #1;
        chk("fl_pred_b", 32'(gs_pred), 1);
        step();
        res_valid = 1'b1; res_taken = 1'b0; #1;
        chk("fl_mis_b", 32'(gs_mispred), 1);
        step();
        chk("fl_spec_b", 32'(dut_gs.spec_ghr), 32'b00010);
        req_valid = 1'b1; req_pc = 32'h40; #1;
        chk("fl_pred_c", 32'(gs_pred), 1);
        step();
        res_valid = 1'b1; res_taken = 1'b1; #1;
        chk("fl_mis_c", 32'(gs_mispred), 0);
        step();
        chk("fl_commit", 32'(dut_gs.commit_ghr), 32'b00101);
        req_valid = 1'b1; req_pc = 32'h00; step();
        req_valid = 1'b1; req_pc = 32'h04; step();
        chk("fl_occ2", 32'(gs_occ), 2);
        flush = 1'b1; req_valid = 1'b1; req_pc = 32'h08; step();
        chk("fl_occ0", 32'(gs_occ), 0);
        chk("fl_spec", 32'(dut_gs.spec_ghr), 32'b00101);
        chk("fl_stat_res", 32'(gs_stat_res), 3);
        chk("fl_stat_mis", 32'(gs_stat_mis), 1);

        // Resolve on an empty FIFO
        res_valid = 1'b1; res_taken = 1'b1; #1;
        chk("emp_mis", 32'(gs_mispred), 0);
        step();
        chk("emp_res_err", 32'(gs_res_err), 1);
        chk("emp_stat_res", 32'(gs_stat_res), 3);
        chk("emp_cnt18", 32'(dut_gs.cnt[18]), 3);
        chk("emp_occ", 32'(gs_occ), 0);

        // Reset in the middle of operation
        req_valid = 1'b1; req_pc = 32'h0c; step();
        chk("mid_occ1", 32'(gs_occ), 1);
        rst = 1'b1; step();
        chk("mid_res_err", 32'(gs_res_err), 0);
        chk("mid_occ0", 32'(gs_occ), 0);
        chk("mid_stat_res", 32'(gs_stat_res), 0);
        chk("mid_ready", 32'(gs_req_ready), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
